// File: rtl/sqrt_invsqrt_iter_core.sv
// sqrt_invsqrt_iter_core: iterative Goldschmidt engine computing sqrt or 1/sqrt of a Q1.(W-1) mantissa
// with valid/ready handshakes, back-to-back issue and a zero-operand exception path.
module sqrt_invsqrt_iter_core #(
    parameter int W      = 9,
    parameter int N_ITER = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic         mode_i,
    input  logic [W-1:0] s_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] res_o,
    output logic         mode_o,
    output logic         err_o
);
    localparam int CW = $clog2(N_ITER + 1);
    localparam logic [W-1:0] C = {2'b11, {(W-2){1'b0}}};

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  b_q, b_d, y_q, y_d, x_q, x_d, res_q, res_d;
    logic          mode_q, mode_d, z_q, z_d, ov_q, ov_d, mo_q, mo_d, err_q, err_d;
    logic [W-1:0]  y0, x0, bk, yk, xk;
    logic [2*W-1:0] p_s, p_x;
    logic [3*W-1:0] p_b;
    logic          accept;

    assign in_ready_o  = rst && (state_q == IDLE || (state_q == DONE && out_ready_i));
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = ov_q;
    assign res_o       = res_q;
    assign mode_o      = mo_q;
    assign err_o       = err_q;

    // Seed step on the incoming operand and one refinement step on the held state.
    always_comb begin
        y0  = C - (s_i >> 1);
        p_s = (2*W)'(s_i) * (2*W)'(y0);
        x0  = W'(p_s >> (W - 1));
        p_b = (3*W)'(b_q) * (3*W)'(y_q) * (3*W)'(y_q);
        bk  = W'(p_b >> (2*W - 2));
        yk  = C - (bk >> 1);
        p_x = (2*W)'(x_q) * (2*W)'(yk);
        xk  = W'(p_x >> (W - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        b_d     = b_q;
        y_d     = y_q;
        x_d     = x_q;
        mode_d  = mode_q;
        z_d     = z_q;
        ov_d    = ov_q;
        res_d   = res_q;
        mo_d    = mo_q;
        err_d   = err_q;
        case (state_q)
            ITER: begin
                b_d   = bk;
                y_d   = yk;
                x_d   = xk;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N_ITER - 1)) begin
                    state_d = DONE;
                    ov_d    = 1'b1;
                    res_d   = z_q ? {W{mode_q}} : xk;
                    mo_d    = mode_q;
                    err_d   = z_q && mode_q;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: ;
        endcase
        if (accept) begin
            state_d = ITER;
            cnt_d   = '0;
            b_d     = s_i;
            y_d     = y0;
            x_d     = mode_i ? y0 : x0;
            mode_d  = mode_i;
            z_d     = (s_i == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            b_q     <= '0;
            y_q     <= '0;
            x_q     <= '0;
            mode_q  <= 1'b0;
            z_q     <= 1'b0;
            ov_q    <= 1'b0;
            res_q   <= '0;
            mo_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            y_q     <= y_d;
            x_q     <= x_d;
            mode_q  <= mode_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
            res_q   <= res_d;
            mo_q    <= mo_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_sqrt_invsqrt_iter_core.sv
// tb_sqrt_invsqrt_iter_core: randomized self-checking bench against an arithmetic model of the
// Goldschmidt recurrence, covering reset, sweep, zero, backpressure, streaming and mid-op reset.
module tb_sqrt_invsqrt_iter_core;
    localparam int W = 9;
    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic         mode_i = 1'b0;
    logic [W-1:0] s_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] res_o;
    logic         mode_o;
    logic         err_o;

    int n_tests = 0;
    int n_fail  = 0;

    sqrt_invsqrt_iter_core #(.W(W), .N_ITER(N)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .mode_i(mode_i), .s_i(s_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .res_o(res_o), .mode_o(mode_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input longint s, input bit m);
        longint msk = (longint'(1) << W) - 1;
        longint c = 3 * (longint'(1) << (W - 2));
        longint b = s;
        longint y = (c - (s >> 1)) & msk;
        longint x = m ? y : ((s * y) >> (W - 1)) & msk;
        for (int k = 0; k < N; k++) begin
            b = ((b * y * y) >> (2 * (W - 1))) & msk;
            y = (c - (b >> 1)) & msk;
            x = ((x * y) >> (W - 1)) & msk;
        end
        if (s == 0) return m ? W'(msk) : '0;
        return W'(x);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one operand from IDLE and wait for its result; lat=99 flags a stuck handshake.
    task automatic issue(input logic [W-1:0] s, input bit m, output int lat);
        int w = 0;
        s_i = s;
        mode_i = m;
        in_valid_i = 1'b1;
        while (!in_ready_o && w < 20) begin tick(); w++; end
        tick();
        in_valid_i = 1'b0;
        lat = 0;
        while (!out_valid_o && lat < 20) begin tick(); lat++; end
        if (!out_valid_o) lat = 99;
    endtask

    task automatic drain;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        in_valid_i = 1'b1;
        s_i = 9'd256;
        tick();
        tick();
        n_tests += 5;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid_o); end
        if (res_o !== '0) begin n_fail++; $display("FAIL reset_res got %0d exp 0", res_o); end
        if (mode_o !== 1'b0) begin n_fail++; $display("FAIL reset_mode got %b exp 0", mode_o); end
        if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err_o); end
        if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", in_ready_o); end
        in_valid_i = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_unity;
        int lat;
        for (int m = 0; m < 2; m++) begin
            issue(9'd256, bit'(m), lat);
            n_tests += 4;
            if (lat !== N) begin n_fail++; $display("FAIL unity_lat m=%0d got %0d exp %0d", m, lat, N); end
            if (res_o !== 9'd256) begin n_fail++; $display("FAIL unity_res m=%0d got %0d exp 256", m, res_o); end
            if (err_o !== 1'b0) begin n_fail++; $display("FAIL unity_err m=%0d got %b exp 0", m, err_o); end
            if (mode_o !== bit'(m)) begin n_fail++; $display("FAIL unity_mode got %b exp %0d", mode_o, m); end
            drain();
        end
    endtask

    task automatic test_half;
        int lat;
        int d;
        for (int m = 0; m < 2; m++) begin
            issue(9'd128, bit'(m), lat);
            d = int'(res_o) - (m ? 362 : 181);
            n_tests += 2;
            if (res_o !== model(128, bit'(m))) begin n_fail++; $display("FAIL half_exact m=%0d got %0d exp %0d", m, res_o, model(128, bit'(m))); end
            if (d > 2 || d < -2) begin n_fail++; $display("FAIL half_close m=%0d got %0d exp %0d+-2", m, res_o, m ? 362 : 181); end
            drain();
        end
    endtask

    task automatic test_sweep;
        int lat;
        int bad = 0;
        for (int m = 0; m < 2; m++)
            for (int s = 128; s < 512; s++) begin
                issue(W'(s), bit'(m), lat);
                n_tests++;
                if (res_o !== model(s, bit'(m)) || lat !== N || err_o !== 1'b0) begin
                    n_fail++;
                    if (bad++ < 10) $display("FAIL sweep s=%0d m=%0d got %0d lat %0d err %b exp %0d lat %0d", s, m, res_o, lat, err_o, model(s, bit'(m)), N);
                end
                drain();
            end
    endtask

    task automatic test_random;
        int lat;
        logic [W-1:0] s;
        bit m;
        for (int i = 0; i < 60; i++) begin
            s = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(128, 511));
            m = bit'($urandom_range(0, 1));
            issue(s, m, lat);
            n_tests++;
            if (res_o !== model(s, m) || err_o !== (s == 0 && m) || mode_o !== m || lat !== N) begin
                n_fail++;
                $display("FAIL random s=%0d m=%0d got %0d err %b mode %b lat %0d exp %0d", s, m, res_o, err_o, mode_o, lat, model(s, m));
            end
            drain();
        end
    endtask

    task automatic test_zero;
        int lat;
        for (int m = 0; m < 2; m++) begin
            issue('0, bit'(m), lat);
            n_tests += 3;
            if (lat !== N) begin n_fail++; $display("FAIL zero_lat m=%0d got %0d exp %0d", m, lat, N); end
            if (res_o !== (m ? 9'h1FF : 9'h000)) begin n_fail++; $display("FAIL zero_res m=%0d got %0h exp %0h", m, res_o, m ? 9'h1FF : 9'h000); end
            if (err_o !== bit'(m)) begin n_fail++; $display("FAIL zero_err m=%0d got %b exp %0d", m, err_o, m); end
            drain();
        end
    endtask

    task automatic test_backpressure;
        int lat;
        logic [W-1:0] r0;
        issue(9'd300, 1'b1, lat);
        r0 = res_o;
        n_tests++;
        if (r0 !== model(300, 1'b1)) begin n_fail++; $display("FAIL bp_first got %0d exp %0d", r0, model(300, 1'b1)); end
        in_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_i = W'($urandom_range(128, 511));
            mode_i = bit'($urandom_range(0, 1));
            n_tests++;
            if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || res_o !== r0 || mode_o !== 1'b1 || err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d ready %b valid %b res %0d mode %b exp ready 0 valid 1 res %0d mode 1", i, in_ready_o, out_valid_o, res_o, mode_o, r0);
            end
            tick();
        end
        s_i = 9'd200;
        mode_i = 1'b0;
        out_ready_i = 1'b1;
        #1;
        n_tests++;
        if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_ready got %b exp 1", in_ready_o); end
        tick();
        in_valid_i = 1'b0;
        out_ready_i = 1'b0;
        n_tests++;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drop got %b exp 0", out_valid_o); end
        lat = 0;
        while (!out_valid_o && lat < 20) begin tick(); lat++; end
        n_tests += 2;
        if (lat !== N) begin n_fail++; $display("FAIL bp_lat got %0d exp %0d", lat, N); end
        if (res_o !== model(200, 1'b0) || mode_o !== 1'b0) begin n_fail++; $display("FAIL bp_reload got %0d mode %b exp %0d mode 0", res_o, mode_o, model(200, 1'b0)); end
        drain();
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] qs[$];
        bit qm[$];
        int last = -1;
        int got = 0;
        bit m = 1'b0;
        logic [W-1:0] es;
        bit em;
        bit acc, hs;
        s_i = W'($urandom_range(128, 511));
        mode_i = m;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        for (int c = 0; c < 60; c++) begin
            acc = in_valid_i && in_ready_o;
            hs = out_valid_o && out_ready_i;
            if (hs) begin
                es = qs.pop_front();
                em = qm.pop_front();
                got++;
                n_tests++;
                if (res_o !== model(es, em) || mode_o !== em) begin n_fail++; $display("FAIL stream_res s=%0d got %0d mode %b exp %0d mode %b", es, res_o, mode_o, model(es, em), em); end
                if (last >= 0) begin
                    n_tests++;
                    if (c - last !== N + 1) begin n_fail++; $display("FAIL stream_gap got %0d exp %0d", c - last, N + 1); end
                end
                last = c;
            end
            if (acc) begin qs.push_back(s_i); qm.push_back(mode_i); end
            tick();
            if (acc) begin
                m = ~m;
                s_i = W'($urandom_range(128, 511));
                mode_i = m;
            end
        end
        n_tests++;
        if (got < 6) begin n_fail++; $display("FAIL stream_count got %0d exp >=6", got); end
        in_valid_i = 1'b0;
        while (out_valid_o || !in_ready_o) tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset_mid;
        int lat;
        s_i = 9'd400;
        mode_i = 1'b1;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_tests += 2;
        if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", out_valid_o); end
        if (in_ready_o !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b exp 0", in_ready_o); end
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_stale cyc=%0d got %b exp 0", i, out_valid_o); end
            tick();
        end
        issue(9'd170, 1'b0, lat);
        n_tests++;
        if (res_o !== model(170, 1'b0) || lat !== N || mode_o !== 1'b0) begin n_fail++; $display("FAIL midrst_fresh got %0d lat %0d exp %0d lat %0d", res_o, lat, model(170, 1'b0), N); end
        drain();
    endtask

    initial begin
        test_reset();
        test_unity();
        test_half();
        test_zero();
        test_sweep();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
